// File: rtl/perf_window_ctrl.sv
// Windowed per-port SA event counters with a snapshot/report stream.
// Define PERF_WINDOW_CTRL_SAT_EN to saturate counters instead of wrapping.
module perf_window_ctrl #(
    parameter int INPUT_PORT_NUM = 5,
    parameter int CNT_W          = 16,
    parameter int WIN_W          = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic                                  stop_i,
    input  logic [WIN_W-1:0]                      win_len_i,
    input  logic [INPUT_PORT_NUM-1:0]             sa_local_vld_i,
    input  logic [INPUT_PORT_NUM-1:0]             sa_global_inport_read_vld_i,
    output logic                                  rpt_vld_o,
    input  logic                                  rpt_rdy_i,
    output logic [$clog2(2*INPUT_PORT_NUM)-1:0]   rpt_idx_o,
    output logic [CNT_W-1:0]                      rpt_data_o,
    output logic                                  rpt_last_o,
    output logic                                  busy_o,
    output logic                                  overrun_o
);

    localparam int NCNT  = 2 * INPUT_PORT_NUM;
    localparam int IDX_W = $clog2(NCNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCNT - 1);

    typedef enum logic {IDLE, RUN}      win_state_t;
    typedef enum logic {R_IDLE, R_SEND} rpt_state_t;

    win_state_t       win_state;
    rpt_state_t       rpt_state;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] live      [NCNT];
    logic [CNT_W-1:0] shadow    [NCNT];
    logic [CNT_W-1:0] live_next [NCNT];

    logic [NCNT-1:0]  ev;
    logic             start_ok;
    logic             terminal;
    logic             snap;
    logic             drop;
    logic [IDX_W-1:0] nxt_idx;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic e);
`ifdef PERF_WINDOW_CTRL_SAT_EN
        return (e && (v != '1)) ? v + CNT_W'(1) : v;
`else
        return v + CNT_W'(e);
`endif
    endfunction

    always_comb begin
        ev       = {sa_global_inport_read_vld_i, sa_local_vld_i};
        start_ok = (win_state == IDLE) && start_i && !stop_i && (win_len_i != '0);
        terminal = (win_state == RUN) && (win_cnt == win_len_q - WIN_W'(1));
        snap     = terminal && (rpt_state == R_IDLE);
        drop     = terminal && (rpt_state == R_SEND);
        nxt_idx  = rpt_idx_o + IDX_W'(1);
        for (int unsigned i = 0; i < NCNT; i++) begin
            live_next[i] = bump(live[i], ev[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_state  <= IDLE;
            rpt_state  <= R_IDLE;
            win_len_q  <= '0;
            win_cnt    <= '0;
            busy_o     <= 1'b0;
            overrun_o  <= 1'b0;
            rpt_vld_o  <= 1'b0;
            rpt_idx_o  <= '0;
            rpt_data_o <= '0;
            rpt_last_o <= 1'b0;
            for (int unsigned i = 0; i < NCNT; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            case (win_state)
                IDLE: begin
                    if (start_ok) begin
                        win_state <= RUN;
                        win_len_q <= win_len_i;
                        win_cnt   <= '0;
                        busy_o    <= 1'b1;
                        overrun_o <= 1'b0;
                    end
                end
                RUN: begin
                    win_cnt <= terminal ? '0 : win_cnt + WIN_W'(1);
                    // A stop on the terminal cycle still snapshots; live values are dropped either way.
                    for (int unsigned i = 0; i < NCNT; i++) begin
                        live[i] <= (terminal || stop_i) ? '0 : live_next[i];
                        if (snap) begin
                            shadow[i] <= live_next[i];
                        end
                    end
                    if (drop) begin
                        overrun_o <= 1'b1;
                    end
                    if (stop_i) begin
                        win_state <= IDLE;
                        busy_o    <= 1'b0;
                    end
                end
                default: win_state <= IDLE;
            endcase

            case (rpt_state)
                R_IDLE: begin
                    if (snap) begin
                        rpt_state  <= R_SEND;
                        rpt_vld_o  <= 1'b1;
                        rpt_idx_o  <= '0;
                        rpt_data_o <= live_next[0];
                        rpt_last_o <= 1'b0;
                    end
                end
                R_SEND: begin
                    if (rpt_rdy_i) begin
                        if (rpt_last_o) begin
                            rpt_state  <= R_IDLE;
                            rpt_vld_o  <= 1'b0;
                            rpt_idx_o  <= '0;
                            rpt_data_o <= '0;
                            rpt_last_o <= 1'b0;
                        end else begin
                            rpt_idx_o  <= nxt_idx;
                            rpt_data_o <= shadow[nxt_idx];
                            rpt_last_o <= (nxt_idx == LAST_IDX);
                        end
                    end
                end
                default: rpt_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perf_window_ctrl.sv
// Bench for perf_window_ctrl: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_perf_window_ctrl;

    localparam int N  = 5;
    localparam int NC = 2 * N;
    localparam int CW = 16;
    localparam int WW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start_i, stop_i, rpt_rdy_i;
    logic [WW-1:0] win_len_i;
    logic [N-1:0]  loc, glb;

    logic          rpt_vld_o, rpt_last_o, busy_o, overrun_o;
    logic [3:0]    rpt_idx_o;
    logic [CW-1:0] rpt_data_o;

    logic          s_vld, s_last, s_busy, s_ovr;
    logic [3:0]    s_idx;
    logic [3:0]    s_data;

    perf_window_ctrl #(.INPUT_PORT_NUM(N), .CNT_W(CW), .WIN_W(WW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .win_len_i(win_len_i),
        .sa_local_vld_i(loc), .sa_global_inport_read_vld_i(glb),
        .rpt_vld_o(rpt_vld_o), .rpt_rdy_i(rpt_rdy_i), .rpt_idx_o(rpt_idx_o),
        .rpt_data_o(rpt_data_o), .rpt_last_o(rpt_last_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    perf_window_ctrl #(.INPUT_PORT_NUM(N), .CNT_W(4), .WIN_W(WW)) dut_small (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .win_len_i(win_len_i),
        .sa_local_vld_i(loc), .sa_global_inport_read_vld_i(glb),
        .rpt_vld_o(s_vld), .rpt_rdy_i(rpt_rdy_i), .rpt_idx_o(s_idx),
        .rpt_data_o(s_data), .rpt_last_o(s_last), .busy_o(s_busy), .overrun_o(s_ovr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: integer event totals per window, report as a queue of beats.
    typedef struct {
        int     idx;
        longint data;
        bit     last;
    } beat_t;

    beat_t  mq[$];
    bit     m_run, m_ovr;
    int     m_pos, m_len;
    longint m_cnt [NC];

    function automatic longint cap(input longint c, input int w);
        longint lim = longint'(1) << w;
`ifdef PERF_WINDOW_CTRL_SAT_EN
        return (c >= lim) ? lim - 1 : c;
`else
        return c % lim;
`endif
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit    in_send;
        beat_t b;
        if (rst) begin
            m_run = 0; m_ovr = 0; m_pos = 0; m_len = 0;
            mq.delete();
            clear_counts();
            return;
        end
        in_send = (mq.size() != 0);
        if (in_send && rpt_rdy_i) void'(mq.pop_front());
        if (m_run) begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i]     += longint'(loc[i]);
                m_cnt[N + i] += longint'(glb[i]);
            end
            m_pos++;
            if (m_pos == m_len) begin
                if (in_send) m_ovr = 1;
                else begin
                    for (int k = 0; k < NC; k++) begin
                        b.idx = k; b.data = cap(m_cnt[k], CW); b.last = (k == NC - 1);
                        mq.push_back(b);
                    end
                end
                clear_counts();
                m_pos = 0;
            end
            if (stop_i) begin
                m_run = 0;
                clear_counts();
            end
        end else if (start_i && !stop_i && win_len_i != 0) begin
            m_run = 1; m_len = int'(win_len_i); m_pos = 0; m_ovr = 0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("vld", rpt_vld_o, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("idx", rpt_idx_o, mq[0].idx);
            chk("data", rpt_data_o, mq[0].data);
            chk("last", rpt_last_o, mq[0].last);
        end
        chk("busy", busy_o, m_run);
        chk("overrun", overrun_o, m_ovr);
    endtask

    task automatic idle_inputs();
        start_i = 0; stop_i = 0; loc = '0; glb = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; cycle(); rst = 0;
    endtask

    typedef struct {
        logic          r, s, p;
        logic [WW-1:0] wl;
        logic [N-1:0]  l, g;
        logic          rd;
        logic          busy, vld;
        logic [3:0]    idx;
        logic [CW-1:0] data;
    } vec_t;

    function automatic vec_t mk(input logic r, s, p, input logic [WW-1:0] wl,
                                input logic [N-1:0] l, g, input logic rd,
                                input logic busy, vld, input logic [3:0] idx,
                                input logic [CW-1:0] data);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.wl = wl; v.l = l; v.g = g; v.rd = rd;
        v.busy = busy; v.vld = vld; v.idx = idx; v.data = data;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        int   n, hold;
        logic [CW-1:0] held;

        tbl[0] = mk(1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
        tbl[1] = mk(0, 1, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 1, 1, 3, 5'b00000, 5'b00000, 0, 0, 0, 0, 0);
        tbl[3] = mk(0, 1, 0, 3, 5'b00000, 5'b00000, 0, 1, 0, 0, 0);
        tbl[4] = mk(0, 0, 0, 3, 5'b00001, 5'b00000, 0, 1, 0, 0, 0);
        tbl[5] = mk(0, 0, 0, 3, 5'b00001, 5'b00000, 0, 1, 0, 0, 0);
        tbl[6] = mk(0, 0, 0, 3, 5'b00001, 5'b00000, 0, 1, 1, 0, 3);
        tbl[7] = mk(0, 0, 1, 3, 5'b00000, 5'b00000, 0, 0, 1, 0, 3);
        tbl[8] = mk(0, 0, 0, 3, 5'b00000, 5'b00000, 1, 0, 1, 1, 0);
        tbl[9] = mk(0, 0, 0, 3, 5'b00000, 5'b11111, 1, 0, 1, 2, 0);

        rst = 1; rpt_rdy_i = 0; win_len_i = '0; idle_inputs();
        for (int r = 0; r < 10; r++) begin
            rst = tbl[r].r; start_i = tbl[r].s; stop_i = tbl[r].p; win_len_i = tbl[r].wl;
            loc = tbl[r].l; glb = tbl[r].g; rpt_rdy_i = tbl[r].rd;
            cycle();
            chk("tbl_busy", busy_o, tbl[r].busy);
            chk("tbl_vld", rpt_vld_o, tbl[r].vld);
            if (tbl[r].vld) begin
                chk("tbl_idx", rpt_idx_o, tbl[r].idx);
                chk("tbl_data", rpt_data_o, tbl[r].data);
            end
        end

        // Basic window: loc[2] high three cycles, first beat one cycle after terminal.
        do_reset();
        rpt_rdy_i = 1; win_len_i = 8; start_i = 1; cycle(); start_i = 0;
        for (int k = 1; k <= 8; k++) begin
            loc = (k >= 2 && k <= 4) ? 5'b00100 : 5'b00000;
            cycle();
            if (k < 8) chk("basic_no_early_vld", rpt_vld_o, 0);
        end
        chk("basic_first_vld", rpt_vld_o, 1);
        loc = '0; stop_i = 1; n = 0;
        for (int t = 0; t < 15; t++) begin
            if (rpt_vld_o) begin
                chk("basic_idx", rpt_idx_o, n);
                chk("basic_data", rpt_data_o, (n == 2) ? 3 : 0);
                chk("basic_last", rpt_last_o, n == 9);
                n++;
            end
            cycle(); stop_i = 0;
        end
        chk("basic_beats", n, 10);

        // Backpressure at idx4 for five cycles.
        do_reset();
        rpt_rdy_i = 1; win_len_i = 6; start_i = 1; cycle(); start_i = 0;
        for (int k = 1; k <= 6; k++) begin
            loc = N'($urandom); glb = N'($urandom); cycle();
        end
        idle_inputs(); stop_i = 1; n = 0; hold = 0; held = '0;
        for (int t = 0; t < 40 && n < 10; t++) begin
            if (rpt_vld_o) begin
                chk("bp_idx", rpt_idx_o, n);
                if (n == 4 && hold < 5) begin
                    if (hold == 0) held = rpt_data_o;
                    else chk("bp_hold_data", rpt_data_o, held);
                    rpt_rdy_i = 0; hold++;
                end else begin
                    rpt_rdy_i = 1; n++;
                end
            end
            cycle(); stop_i = 0;
        end
        chk("bp_beats", n, 10);
        chk("bp_stall_cycles", hold, 5);

        // Overrun with permanent backpressure, then cleared by a new start.
        do_reset();
        rpt_rdy_i = 0; win_len_i = 4; start_i = 1; cycle(); start_i = 0;
        loc = 5'b00001;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 4) chk("ovr_beat0_first", rpt_data_o, 4);
            if (k == 7) chk("ovr_not_yet", overrun_o, 0);
        end
        chk("ovr_set", overrun_o, 1);
        chk("ovr_beat0_kept", rpt_data_o, 4);
        chk("ovr_idx_kept", rpt_idx_o, 0);
        loc = '0; stop_i = 1; cycle(); stop_i = 0;
        chk("ovr_sticky_after_stop", overrun_o, 1);
        start_i = 1; cycle(); start_i = 0;
        chk("ovr_cleared_by_start", overrun_o, 0);
        chk("ovr_restart_busy", busy_o, 1);

        // Stop mid-window produces no report; zero-length start is ignored.
        do_reset();
        rpt_rdy_i = 1; win_len_i = 6; start_i = 1; cycle(); start_i = 0;
        loc = '1; glb = '1;
        for (int k = 1; k <= 3; k++) cycle();
        stop_i = 1; cycle(); stop_i = 0; idle_inputs();
        chk("stop_busy_low", busy_o, 0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("stop_no_report", rpt_vld_o, 0);
        end
        win_len_i = 0; start_i = 1; cycle(); start_i = 0;
        chk("zero_len_start_idle", busy_o, 0);

        // Saturation / wrap on the 4-bit instance: 20 events on global port 0.
        do_reset();
        rpt_rdy_i = 1; win_len_i = 20; glb = 5'b00001; start_i = 1; cycle(); start_i = 0;
        for (int k = 1; k <= 20; k++) cycle();
        stop_i = 1; cycle(); stop_i = 0;
        for (int k = 22; k <= 25; k++) cycle();
        chk("sat_vld", s_vld, 1);
        chk("sat_idx", s_idx, 5);
`ifdef PERF_WINDOW_CTRL_SAT_EN
        chk("sat_data", s_data, 15);
`else
        chk("wrap_data", s_data, 4);
`endif
        glb = '0;

        // Reset while a report is in flight at idx3.
        do_reset();
        rpt_rdy_i = 1; win_len_i = 2; start_i = 1; cycle(); start_i = 0;
        loc = 5'b10101; cycle(); cycle(); loc = '0;
        stop_i = 1; cycle(); stop_i = 0; cycle(); cycle();
        chk("mid_rst_pre_idx", rpt_idx_o, 3);
        rst = 1; cycle(); rst = 0;
        chk("mid_rst_vld", rpt_vld_o, 0);
        chk("mid_rst_idx", rpt_idx_o, 0);
        chk("mid_rst_data", rpt_data_o, 0);
        chk("mid_rst_last", rpt_last_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_ovr", overrun_o, 0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("mid_rst_no_beats", rpt_vld_o, 0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 2000; t++) begin
            start_i   = (!busy_o && ($urandom % 6 == 0));
            win_len_i = WW'($urandom_range(0, 10));
            stop_i    = ($urandom % 50 == 0);
            loc       = N'($urandom);
            glb       = N'($urandom);
            rpt_rdy_i = ($urandom % 4 != 0);
            rst       = ($urandom % 500 == 0);
            cycle();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_window_ctrl.md
PERF_WINDOW_CTRL -- requirements
Module: perf_window_ctrl

Interface
REQ-001 SHALL have parameter INPUT_PORT_NUM, default 5: number of router input ports monitored.
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-port window event counter.
REQ-003 SHALL have parameter WIN_W, default 32: width of the window-length configuration.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1: begin windowed sampling.
REQ-007 SHALL have port stop_i, input, 1: end sampling and discard the partial window.
REQ-008 SHALL have port win_len_i, input, WIN_W: window length in cycles, latched on accepted start.
REQ-009 SHALL have port sa_local_vld_i, input, INPUT_PORT_NUM: per-port SA local-valid event.
REQ-010 SHALL have port sa_global_inport_read_vld_i, input, INPUT_PORT_NUM: per-port SA global read event.
REQ-011 SHALL have port rpt_vld_o, output, 1: report beat valid.
REQ-012 SHALL have port rpt_rdy_i, input, 1: report beat ready.
REQ-013 SHALL have port rpt_idx_o, output, $clog2(2*INPUT_PORT_NUM): counter index of the current beat.
REQ-014 SHALL have port rpt_data_o, output, CNT_W: counter value of the current beat.
REQ-015 SHALL have port rpt_last_o, output, 1: current beat is the final one, idx 2*INPUT_PORT_NUM-1.
REQ-016 SHALL have port busy_o, output, 1: window FSM is in RUN.
REQ-017 SHALL have port overrun_o, output, 1: sticky flag, a snapshot was dropped.

Function
REQ-018 SHALL implement a window FSM with states IDLE and RUN.
- IDLE->RUN: start_i=1, stop_i=0, win_len_i!=0 in cycle C.
- win_len_i is latched in C; start_i with win_len_i==0 is ignored.
REQ-019 SHALL count events on cycles C+1..C+L inclusive as window 0, where L is the latched length; subsequent windows follow back-to-back with no gap.
REQ-020 SHALL keep 2*INPUT_PORT_NUM live counters: index p counts sa_local_vld_i[p]; index INPUT_PORT_NUM+p counts sa_global_inport_read_vld_i[p]; each increments by 1 per asserted cycle.
REQ-021 SHALL, on the terminal cycle of each window, load the shadow copy with each live value plus that cycle's event, and clear the live counters to 0 for the next window.
REQ-022 SHALL implement an independent report FSM with states R_IDLE and R_SEND; a snapshot moves R_IDLE->R_SEND and drives rpt_vld_o=1 in the cycle after the terminal cycle, at idx 0.
REQ-023 SHALL hold rpt_idx_o, rpt_data_o and rpt_last_o stable while rpt_vld_o=1 and rpt_rdy_i=0.
- Handshake (vld&rdy) at idx k<2N-1 advances to k+1.
- Handshake at the last idx returns to R_IDLE.
REQ-024 SHALL, if a window terminates while the report FSM is in R_SEND, drop the new snapshot, leave the shadow and beat in flight untouched, set overrun_o=1, and still clear the live counters.
REQ-025 SHALL clear overrun_o only on reset or on an accepted start_i.
REQ-026 SHALL, on stop_i=1 in RUN, go to IDLE next cycle, clear the live counters and produce no snapshot; a report in flight completes normally.
REQ-027 SHALL give stop_i priority when start_i and stop_i are both asserted; start_i in RUN is ignored.
REQ-028 SHALL, on a stop in the terminal cycle, take the snapshot first and then go to IDLE.
REQ-029 SHALL assert busy_o=1 exactly while in RUN.

Reset
REQ-030 SHALL, with rst=1 at a clock edge, force IDLE and R_IDLE and clear all live counters, shadow registers, the window count and the latched length.
REQ-031 SHALL force rpt_vld_o=0, rpt_idx_o=0, rpt_data_o=0, rpt_last_o=0, busy_o=0 and overrun_o=0 on reset.
REQ-032 SHALL abort a report in flight when reset is asserted mid-report, with no further beats.

Configuration
REQ-033 SHALL, with PERF_WINDOW_CTRL_SAT_EN defined, saturate every live counter at 2^CNT_W-1 (terminal-cycle add included).
REQ-034 SHALL, without PERF_WINDOW_CTRL_SAT_EN, let every live counter wrap modulo 2^CNT_W.

Verification
REQ-035 SHALL cover a basic window: win_len=8, start, sa_local_vld_i[2] high for 3 cycles inside the window -> 10 beats idx 0..9, idx2 data=3, all others 0, rpt_last_o on idx9, first vld at C+9.
REQ-036 SHALL cover backpressure: rpt_rdy_i low 5 cycles at idx4 -> idx/data held stable, then resume with no beat lost or repeated.
REQ-037 SHALL cover overrun: win_len=4, rpt_rdy_i=0 permanently -> overrun_o=1 at the second terminal cycle and beat 0 data unchanged; a new start clears it.
REQ-038 SHALL cover stop and illegal start: stop_i mid-window -> no report and busy_o=0 next cycle; start with win_len_i=0 -> stays IDLE.
REQ-039 SHALL cover saturation: CNT_W=4, win_len=20, sa_global_inport_read_vld_i[0] held high -> idx5 reports 15 with SAT_EN, 20 mod 16=4 without.
REQ-040 SHALL cover mid-report reset: rst pulsed while rpt_vld_o=1 at idx3 -> next cycle all outputs are 0 and the FSMs are idle.
